gray_mod_fsm: RTL and testbench

Parametrised Moore state machine that steps through N states on qualified input events, with the state register held in binary-reflected Gray code. Generalises the fixed 3-state Gray-coded step FSM: configurable state count, up/down direction, synchronous clear, wrap pulse and threshold output. Sits between a debounced/strobed event input and downstream control logic that decodes the state or the "not idle" flag.

---
 rtl/gray_mod_fsm.sv | 125 ++++++++++++
 tb/tb_gray_mod_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_mod_fsm.sv
// gray_mod_fsm: N-state Moore stepper with a Gray-coded state register.
// Steps up or down on qualified events (en && a), with synchronous clear,
// a one-cycle wrap pulse and registered "not idle" / threshold flags.
// The Gray value is the only index state; the binary index is decoded
// combinationally from it, so both views always agree.
module gray_mod_fsm #(
  parameter int N   = 3,
  parameter int W   = $clog2(N),
  parameter int THR = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         a,
  input  logic         dir,
  input  logic         clr,
  output logic [W-1:0] state_gray,
  output logic [W-1:0] state_idx,
  output logic         y,
  output logic         thr,
  output logic         wrap
);

  localparam logic [W-1:0] IDX_MAX = W'(N - 1);
  localparam logic [W-1:0] IDX_THR = W'(THR);
  localparam logic         THR_RST = (THR == 0);

  logic [W-1:0] gray_q;
  logic         y_q;
  logic         thr_q;
  logic         wrap_q;

  logic [W-1:0] cur_idx;
  logic [W-1:0] nxt_idx;
  logic         nxt_wrap;
  logic         nxt_thr;
  logic         illegal;
  logic         step;

  // Binary-reflected Gray code to binary: bit i is the XOR of all Gray bits >= i.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int unsigned k = 1; k < W; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  // Binary to Gray code.
  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign cur_idx = gray2bin(gray_q);
  assign step    = en & a;

  // Codes decoding past N-1 exist only when N is not a power of two.
  generate
    if ((1 << W) == N) begin : g_no_illegal
      assign illegal = 1'b0;
    end else begin : g_illegal
      localparam logic [W:0] N_EXT = N[W:0];
      assign illegal = ({1'b0, cur_idx} >= N_EXT);
    end
  endgenerate

  // Next index and wrap flag, priority: illegal recovery, clear, step, hold.
  always_comb begin
    nxt_idx  = cur_idx;
    nxt_wrap = 1'b0;
    if (illegal) begin
      nxt_idx = '0;
    end else if (clr) begin
      nxt_idx = '0;
    end else if (step) begin
      if (!dir) begin
        if (cur_idx == IDX_MAX) begin
          nxt_idx  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = cur_idx + W'(1);
        end
      end else begin
        if (cur_idx == '0) begin
          nxt_idx  = IDX_MAX;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = cur_idx - W'(1);
        end
      end
    end
  end

  // A threshold of zero is always met; avoid a constant unsigned compare.
  generate
    if (THR == 0) begin : g_thr_zero
      assign nxt_thr = 1'b1;
    end else begin : g_thr_cmp
      assign nxt_thr = (nxt_idx >= IDX_THR);
    end
  endgenerate

  // State and flags are registered together from the next index so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      y_q    <= 1'b0;
      thr_q  <= THR_RST;
      wrap_q <= 1'b0;
    end else begin
      gray_q <= bin2gray(nxt_idx);
      y_q    <= (nxt_idx != '0);
      thr_q  <= nxt_thr;
      wrap_q <= nxt_wrap;
    end
  end

  assign state_gray = gray_q;
  assign state_idx  = cur_idx;
  assign y          = y_q;
  assign thr        = thr_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_gray_mod_fsm.sv
// Directed self-checking bench for gray_mod_fsm: default N=3, N=5 and N=2/THR=0.
module tb_gray_mod_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=3 instance (default parameters, THR=2)
  logic       rst3 = 1'b0, en3 = 1'b0, a3 = 1'b0, dir3 = 1'b0, clr3 = 1'b0;
  logic [1:0] g3, i3;
  logic       y3, t3, w3;

  // N=5 instance (W=3, THR=4)
  logic       rst5 = 1'b0, en5 = 1'b0, a5 = 1'b0, dir5 = 1'b0, clr5 = 1'b0;
  logic [2:0] g5, i5;
  logic       y5, t5, w5;

  // N=2 instance with THR=0 (W=1)
  logic       rst2 = 1'b0, en2 = 1'b0, a2 = 1'b0, dir2 = 1'b0, clr2 = 1'b0;
  logic [0:0] g2, i2;
  logic       y2, t2, w2;

  gray_mod_fsm u_n3 (
    .clk(clk), .rst_n(rst3), .en(en3), .a(a3), .dir(dir3), .clr(clr3),
    .state_gray(g3), .state_idx(i3), .y(y3), .thr(t3), .wrap(w3)
  );

  gray_mod_fsm #(.N(5)) u_n5 (
    .clk(clk), .rst_n(rst5), .en(en5), .a(a5), .dir(dir5), .clr(clr5),
    .state_gray(g5), .state_idx(i5), .y(y5), .thr(t5), .wrap(w5)
  );

  gray_mod_fsm #(.N(2), .THR(0)) u_n2 (
    .clk(clk), .rst_n(rst2), .en(en2), .a(a2), .dir(dir2), .clr(clr2),
    .state_gray(g2), .state_idx(i2), .y(y2), .thr(t2), .wrap(w2)
  );

  task automatic test_reset;
    logic [1:0] eg [3] = '{2'b01, 2'b11, 2'b00};
    logic [1:0] ei [3] = '{2'd1, 2'd2, 2'd0};
    logic       ey [3] = '{1'b1, 1'b1, 1'b0};
    logic       et [3] = '{1'b0, 1'b1, 1'b0};
    logic       ew [3] = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    checks++;
    if ({g3, i3, y3, t3, w3} !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_n3: g=%b idx=%0d y=%b thr=%b wrap=%b, want 00/0/0/0/0", g3, i3, y3, t3, w3);
    end
    @(negedge clk);
    rst3 = 1'b1; en3 = 1'b1; a3 = 1'b1; dir3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (g3 !== eg[k] || i3 !== ei[k] || y3 !== ey[k] || t3 !== et[k] || w3 !== ew[k]) begin
        errors++;
        $display("FAIL reset_step%0d: g=%b idx=%0d y=%b thr=%b wrap=%b, want %b/%0d/%b/%b/%b",
                 k, g3, i3, y3, t3, w3, eg[k], ei[k], ey[k], et[k], ew[k]);
      end
    end
    @(negedge clk);
    a3 = 1'b0; en3 = 1'b0;
  endtask

  task automatic test_hold;
    // from idx 0, one step to idx 1 (gray 01)
    @(negedge clk);
    en3 = 1'b1; a3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0; a3 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        en3 = 1'b1; a3 = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (g3 !== 2'b01 || y3 !== 1'b1 || w3 !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: g=%b y=%b wrap=%b, want 01/1/0", k, g3, y3, w3);
      end
      @(negedge clk);
    end
    en3 = 1'b0;
  endtask

  task automatic test_up_down;
    logic [2:0] eg [5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b000};
    logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       et [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] prev;
    @(negedge clk);
    rst5 = 1'b1; en5 = 1'b1; a5 = 1'b1; dir5 = 1'b0;
    prev = 3'b000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (g5 !== eg[k] || w5 !== ew[k] || t5 !== et[k]) begin
        errors++;
        $display("FAIL up%0d: g=%b wrap=%b thr=%b, want %b/%b/%b", k, g5, w5, t5, eg[k], ew[k], et[k]);
      end
      if (!ew[k]) begin
        checks++;
        if ($countones(prev ^ g5) != 1) begin
          errors++;
          $display("FAIL onebit%0d: %b -> %b changed %0d bits, want 1", k, prev, g5, $countones(prev ^ g5));
        end
      end
      prev = g5;
    end
    @(negedge clk);
    dir5 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (g5 !== 3'b110 || i5 !== 3'd4 || w5 !== 1'b1 || y5 !== 1'b1 || t5 !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: g=%b idx=%0d wrap=%b y=%b thr=%b, want 110/4/1/1/1", g5, i5, w5, y5, t5);
    end
    // direction change again, no turnaround cycle: 4 -> 0 (wrap up)
    @(negedge clk);
    dir5 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (g5 !== 3'b000 || w5 !== 1'b1) begin
      errors++;
      $display("FAIL dir_flip: g=%b wrap=%b, want 000/1", g5, w5);
    end
    @(negedge clk);
    en5 = 1'b0; a5 = 1'b0;
  endtask

  task automatic test_clr;
    @(negedge clk);
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1; en3 = 1'b1; a3 = 1'b1; dir3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (i3 !== 2'd2) begin
      errors++;
      $display("FAIL clr_setup: idx=%0d, want 2", i3);
    end
    @(negedge clk);
    clr3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i3 !== 2'd0 || g3 !== 2'b00 || y3 !== 1'b0 || w3 !== 1'b0) begin
      errors++;
      $display("FAIL clr_vs_step: idx=%0d g=%b y=%b wrap=%b, want 0/00/0/0", i3, g3, y3, w3);
    end
    @(negedge clk);
    clr3 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    en3 = 1'b0; a3 = 1'b0; clr3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i3 !== 2'd0 || y3 !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_en: idx=%0d y=%b, want 0/0", i3, y3);
    end
    @(negedge clk);
    clr3 = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    clr5 = 1'b1;
    @(negedge clk);
    clr5 = 1'b0; en5 = 1'b1; a5 = 1'b1; dir5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (i5 !== 3'd3 || g5 !== 3'b010) begin
      errors++;
      $display("FAIL async_setup: idx=%0d g=%b, want 3/010", i5, g5);
    end
    @(negedge clk);
    a5 = 1'b0;
    #1 rst5 = 1'b0;
    #1;
    checks++;
    if ({g5, i5, y5, t5, w5} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: g=%b idx=%0d y=%b thr=%b wrap=%b, want 000/0/0/0/0", g5, i5, y5, t5, w5);
    end
    @(negedge clk);
    rst5 = 1'b1; a5 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (i5 !== 3'd1 || g5 !== 3'b001) begin
      errors++;
      $display("FAIL async_first_step: idx=%0d g=%b, want 1/001", i5, g5);
    end
    @(negedge clk);
    en5 = 1'b0; a5 = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic ew [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic eg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    checks++;
    if (t2 !== 1'b1 || g2 !== 1'b0 || w2 !== 1'b0 || y2 !== 1'b0) begin
      errors++;
      $display("FAIL n2_reset: thr=%b g=%b wrap=%b y=%b, want 1/0/0/0", t2, g2, w2, y2);
    end
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b1; a2 = 1'b1; dir2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (g2 !== eg[k] || w2 !== ew[k] || t2 !== 1'b1) begin
        errors++;
        $display("FAIL n2_step%0d: g=%b wrap=%b thr=%b, want %b/%b/1", k, g2, w2, t2, eg[k], ew[k]);
      end
    end
    @(negedge clk);
    en2 = 1'b0; a2 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_hold();
    test_up_down();
    test_clr();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
